// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC and runs req/ack to imem, buffering one instruction plus PC+4 for IF/ID.
// Latency: first valid 2 cycles after start with zero-wait memory, then 1 instruction per 2 cycles.
// Backpressure: stall_i holds the buffered entry and blocks new requests; redirects flush and drain in-flight fetches.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                buf_valid_q, buf_valid_d;
  logic [31:0]         buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0]   buf_pc4_q, buf_pc4_d;

  logic                redirect;
  logic [ADDR_W-1:0]   target;
  logic                consume;
  logic [ADDR_W-1:0]   req_pc4;

  // Branch wins over jump when both fire; +4 wraps modulo 2^ADDR_W.
  assign redirect = branch_i | jump_i;
  assign target   = branch_i ? branch_addr_i : jump_addr_i;
  assign consume  = buf_valid_q & ~stall_i;
  assign req_pc4  = req_addr_q + ADDR_W'(4);

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pc_d    = RESET_PC;
          state_d = S_READY;
        end
      end

      S_READY: begin
        if (redirect) begin
          pc_d        = target;
          buf_valid_d = 1'b0;
        end else if (!buf_valid_q || consume) begin
          req_addr_d  = pc_q;
          buf_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          // Any data returning now belongs to the old stream and is dropped.
          pc_d    = target;
          state_d = imem_ack_i ? S_READY : S_DRAIN;
        end else if (imem_ack_i) begin
          buf_instr_d = imem_data_i;
          buf_pc4_d   = req_pc4;
          buf_valid_d = 1'b1;
          pc_d        = req_pc4;
          state_d     = S_READY;
        end
      end

      S_DRAIN: begin
        // Keep the stale request up until memory answers, then throw the data away.
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack_i) begin
          state_d = S_READY;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      req_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  // Empty buffer presents a NOP bubble (all zeros).
  assign instr_o     = buf_valid_q ? buf_instr_q : 32'h0;
  assign addr_o      = buf_valid_q ? buf_pc4_q : '0;
  assign valid_o     = buf_valid_q;
  assign imem_req_o  = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign imem_addr_o = req_addr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch sequencing, stall hold, redirect drain/flush, reset, PC wrap.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall_i and delayed imem_ack_i driven explicitly per step.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;
  bit auto_mem = 1'b0;

  if_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .branch_addr_i(branch_addr_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .instr_o      (instr_o),
    .addr_o       (addr_o),
    .valid_o      (valid_o)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; in auto mode the memory answers in the same cycle with data = address.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_ack_i  = imem_req_o;
      imem_data_i = imem_addr_o;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid_o},    32'd0);
    chk({tag, "_instr"}, instr_o,             32'd0);
    chk({tag, "_addr"},  addr_o,              32'd0);
    chk({tag, "_iaddr"}, imem_addr_o,         32'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    branch_i = 1'b0; branch_addr_i = '0; jump_i = 1'b0; jump_addr_i = '0;
    imem_ack_i = 1'b0; imem_data_i = '0;

    // Reset state
    tick(); tick();
    chk_idle_outputs("reset");
    rst_i = 1'b0;

    // Zero-wait sequential fetch, data = address
    auto_mem = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("seq_ready_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("seq_req0", {31'd0, imem_req_o}, 32'd1);
    chk("seq_iaddr0", imem_addr_o, 32'h0);
    tick();
    chk("seq_valid0", {31'd0, valid_o}, 32'd1);
    chk("seq_instr0", instr_o, 32'h0);
    chk("seq_addr0", addr_o, 32'h4);
    tick();
    chk("seq_gap_valid", {31'd0, valid_o}, 32'd0);
    chk("seq_iaddr4", imem_addr_o, 32'h4);
    tick();
    chk("seq_instr4", instr_o, 32'h4);
    chk("seq_addr4", addr_o, 32'h8);
    tick();
    chk("seq_iaddr8", imem_addr_o, 32'h8);
    tick();
    chk("seq_instr8", instr_o, 32'h8);
    chk("seq_addr8", addr_o, 32'hC);
    auto_mem = 1'b0;
    imem_ack_i = 1'b0;

    // Stall holds the buffer and blocks the next request
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    imem_ack_i = 1'b1; imem_data_i = 32'h8C01_0004; stall_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    chk("stall_fill_instr", instr_o, 32'h8C01_0004);
    chk("stall_fill_addr", addr_o, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_instr", instr_o, 32'h8C01_0004);
      chk("stall_hold_req", {31'd0, imem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick();
    chk("stall_release_iaddr", imem_addr_o, 32'h4);
    chk("stall_release_req", {31'd0, imem_req_o}, 32'd1);
    chk("stall_release_valid", {31'd0, valid_o}, 32'd0);

    // Branch during WAIT with delayed ack: stale fetch drained and dropped
    branch_i = 1'b1; branch_addr_i = 32'h40;
    tick();
    branch_i = 1'b0;
    chk("drain_iaddr_a", imem_addr_o, 32'h4);
    chk("drain_req_a", {31'd0, imem_req_o}, 32'd1);
    tick();
    chk("drain_iaddr_b", imem_addr_o, 32'h4);
    tick();
    chk("drain_iaddr_c", imem_addr_o, 32'h4);
    imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
    tick();
    imem_ack_i = 1'b0;
    chk("drain_discard_valid", {31'd0, valid_o}, 32'd0);
    chk("drain_discard_instr", instr_o, 32'h0);
    chk("drain_done_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("redir_iaddr", imem_addr_o, 32'h40);
    imem_ack_i = 1'b1; imem_data_i = 32'h1111_1111;
    tick();
    imem_ack_i = 1'b0;
    chk("redir_valid", {31'd0, valid_o}, 32'd1);
    chk("redir_addr", addr_o, 32'h44);
    chk("redir_instr", instr_o, 32'h1111_1111);

    // Branch and jump together under stall: branch wins, buffer flushed
    branch_i = 1'b1; branch_addr_i = 32'h80;
    jump_i = 1'b1; jump_addr_i = 32'hC0;
    stall_i = 1'b1;
    tick();
    branch_i = 1'b0; jump_i = 1'b0;
    chk("both_flush_valid", {31'd0, valid_o}, 32'd0);
    chk("both_flush_instr", instr_o, 32'h0);
    chk("both_flush_addr", addr_o, 32'h0);
    tick();
    chk("both_iaddr", imem_addr_o, 32'h80);
    chk("both_req", {31'd0, imem_req_o}, 32'd1);
    stall_i = 1'b0;
    imem_ack_i = 1'b1; imem_data_i = 32'h2222_2222;
    tick();
    imem_ack_i = 1'b0;
    chk("both_fill_addr", addr_o, 32'h84);

    // Reset while draining drops the request at once
    tick();
    chk("pre_drain_iaddr", imem_addr_o, 32'h84);
    jump_i = 1'b1; jump_addr_i = 32'h100;
    tick();
    jump_i = 1'b0;
    chk("in_drain_req", {31'd0, imem_req_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_idle_outputs("rst_drain");
    branch_i = 1'b1; branch_addr_i = 32'h200;
    tick();
    branch_i = 1'b0;
    chk("idle_ignores_redirect", {31'd0, imem_req_o}, 32'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("restart_iaddr", imem_addr_o, 32'h0);
    chk("restart_req", {31'd0, imem_req_o}, 32'd1);

    // PC+4 wraps from the top of the address space
    imem_ack_i = 1'b1; imem_data_i = 32'h3333_3333;
    tick();
    imem_ack_i = 1'b0;
    chk("wrap_pre_addr", addr_o, 32'h4);
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_i = 1'b0;
    tick();
    chk("wrap_iaddr", imem_addr_o, 32'hFFFF_FFFC);
    imem_ack_i = 1'b1; imem_data_i = 32'h4444_4444;
    tick();
    imem_ack_i = 1'b0;
    chk("wrap_valid", {31'd0, valid_o}, 32'd1);
    chk("wrap_addr", addr_o, 32'h0);
    chk("wrap_instr", instr_o, 32'h4444_4444);
    tick();
    chk("wrap_next_iaddr", imem_addr_o, 32'h0);

    // Redirect coinciding with ack: returned data is dropped
    branch_i = 1'b1; branch_addr_i = 32'h50;
    imem_ack_i = 1'b1; imem_data_i = 32'h5555_5555;
    tick();
    branch_i = 1'b0; imem_ack_i = 1'b0;
    chk("ackredir_valid", {31'd0, valid_o}, 32'd0);
    chk("ackredir_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    chk("ackredir_iaddr", imem_addr_o, 32'h50);
    imem_ack_i = 1'b1; imem_data_i = 32'h6666_6666;
    tick();
    imem_ack_i = 1'b0;
    chk("ackredir_addr", addr_o, 32'h54);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
